run_monitor: RTL and testbench

Synthesizable run monitor that sits directly downstream of the pipelined RISC-V `top` and consumes its data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and the fetch `PC`. It captures stores into a 4-word result window and detects program halt or timeout. At halt it compares the captured window against expected FP32 constants and reports pass/fail. This lets FPGA and emulation runs self-check the matrix-multiply program without a behavioural bench.

---
 rtl/run_monitor.sv | 136 +++++++++++++
 tb/tb_run_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// Run monitor for the pipelined core: captures stores into a 4-word result window and
// reports halt/timeout plus a pass verdict against expected FP32 bit patterns.
module run_monitor #(
    parameter logic [31:0] HALT_PC    = 32'h0000_0074,
    parameter int unsigned MIN_CYCLES = 50,
    parameter int unsigned MAX_CYCLES = 500,
    parameter logic [31:0] WIN_BASE   = 32'h0000_0020,
    parameter logic [31:0] EXP0       = 32'h4080_0000,
    parameter logic [31:0] EXP1       = 32'h40A0_0000,
    parameter logic [31:0] EXP2       = 32'h40E0_0000,
    parameter logic [31:0] EXP3       = 32'h4110_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic        misalign,
    output logic [3:0]  win_written,
    output logic [15:0] cycles,
    output logic [15:0] store_count
);

    typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

    state_e           state_q, state_d;
    logic [3:0][31:0] win_q, win_d;
    logic [3:0]       win_written_q, win_written_d;
    logic [15:0]      cycles_q, cycles_d;
    logic [15:0]      store_count_q, store_count_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             misalign_q, misalign_d;

    logic        in_win;
    logic [1:0]  idx;
    logic [31:0] n_ext;
    logic        halt_hit;
    logic        tmo_hit;
    logic        win_match;

    assign in_win = (DataAdr[31:4] == WIN_BASE[31:4]);
    assign idx    = DataAdr[3:2];

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        win_written_d = win_written_q;
        cycles_d      = cycles_q;
        store_count_d = store_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        misalign_d    = misalign_q;
        n_ext         = 32'd0;
        halt_hit      = 1'b0;
        tmo_hit       = 1'b0;
        win_match     = 1'b0;

        if (state_q == StRun) begin
            if (cycles_q != 16'hFFFF) begin
                cycles_d = cycles_q + 16'd1;
            end
            n_ext = {16'd0, cycles_d};

            if (MemWrite) begin
                if (store_count_q != 16'hFFFF) begin
                    store_count_d = store_count_q + 16'd1;
                end
                if (in_win) begin
                    if (DataAdr[1:0] == 2'b00) begin
                        win_d[idx]         = WriteData;
                        win_written_d[idx] = 1'b1;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end

            halt_hit = (PC == HALT_PC) && (n_ext > MIN_CYCLES);
            tmo_hit  = (n_ext >= MAX_CYCLES);

            // Verdict uses next-state window so a store on the halt edge is included.
            win_match = (win_d[0] == EXP0) && (win_d[1] == EXP1) &&
                        (win_d[2] == EXP2) && (win_d[3] == EXP3);

            if (halt_hit) begin
                state_d = StHalted;
                done_d  = 1'b1;
                pass_d  = (&win_written_d) && win_match && !misalign_d;
            end else if (tmo_hit) begin
                state_d   = StTimeout;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            win_q         <= '0;
            win_written_q <= 4'd0;
            cycles_q      <= 16'd0;
            store_count_q <= 16'd0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            win_written_q <= win_written_d;
            cycles_q      <= cycles_d;
            store_count_q <= store_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            misalign_q    <= misalign_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign misalign    = misalign_q;
    assign win_written = win_written_q;
    assign cycles      = cycles_q;
    assign store_count = store_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: halt/pass, wrong data, halt-edge store, timeout,
// misaligned store and asynchronous mid-run reset.
module tb_run_monitor;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        misalign;
    logic [3:0]  win_written;
    logic [15:0] cycles;
    logic [15:0] store_count;

    int n_vectors;
    int n_miscompares;

    run_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .misalign    (misalign),
        .win_written (win_written),
        .cycles      (cycles),
        .store_count (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        PC        = 32'd0;
        MemWrite  = 1'b0;
        DataAdr   = 32'd0;
        WriteData = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic wait_done(input int max_steps);
        int k;
        k = 0;
        while (!done && k < max_steps) begin
            step();
            k++;
        end
        check("wait_done_bound", {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
        check({tag, "_win_written"}, {28'd0, win_written}, 32'd0);
        check({tag, "_cycles"}, {16'd0, cycles}, 32'd0);
        check({tag, "_store_count"}, {16'd0, store_count}, 32'd0);
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;

        // Reset state
        do_reset();
        check_all_zero("reset");

        // Full correct run with one out-of-window store
        store(32'h20, 32'h4080_0000);
        check("a_sc1", {16'd0, store_count}, 32'd1);
        check("a_ww1", {28'd0, win_written}, 32'h1);
        store(32'h24, 32'h40A0_0000);
        store(32'h28, 32'h40E0_0000);
        store(32'h2C, 32'h4110_0000);
        store(32'h30, 32'hDEAD_BEEF);
        check("a_sc5", {16'd0, store_count}, 32'd5);
        check("a_wwF", {28'd0, win_written}, 32'hF);
        check("a_cyc5", {16'd0, cycles}, 32'd5);
        PC = 32'h74;
        wait_done(100);
        check("a_cycles", {16'd0, cycles}, 32'd51);
        check("a_pass", {31'd0, pass}, 32'd1);
        check("a_timeout", {31'd0, timeout}, 32'd0);
        store(32'h20, 32'h0);
        check("a_hold_sc", {16'd0, store_count}, 32'd5);
        check("a_hold_cyc", {16'd0, cycles}, 32'd51);
        check("a_hold_pass", {31'd0, pass}, 32'd1);

        // Wrong C[1][1]
        do_reset();
        store(32'h20, 32'h4080_0000);
        store(32'h24, 32'h40A0_0000);
        store(32'h28, 32'h40E0_0000);
        store(32'h2C, 32'h4100_0000);
        PC = 32'h74;
        wait_done(100);
        check("b_pass", {31'd0, pass}, 32'd0);
        check("b_ww", {28'd0, win_written}, 32'hF);

        // Halt PC from cycle 1, only three words written
        do_reset();
        PC = 32'h74;
        store(32'h20, 32'h4080_0000);
        store(32'h24, 32'h40A0_0000);
        store(32'h28, 32'h40E0_0000);
        repeat (47) step();
        check("c_cyc50", {16'd0, cycles}, 32'd50);
        check("c_nodone50", {31'd0, done}, 32'd0);
        step();
        check("c_done51", {31'd0, done}, 32'd1);
        check("c_cyc51", {16'd0, cycles}, 32'd51);
        check("c_pass", {31'd0, pass}, 32'd0);
        check("c_ww", {28'd0, win_written}, 32'h7);

        // Fourth word stored on the halt edge is included
        do_reset();
        PC = 32'h74;
        store(32'h20, 32'h4080_0000);
        store(32'h24, 32'h40A0_0000);
        store(32'h28, 32'h40E0_0000);
        repeat (47) step();
        store(32'h2C, 32'h4110_0000);
        check("d_done", {31'd0, done}, 32'd1);
        check("d_pass", {31'd0, pass}, 32'd1);
        check("d_ww", {28'd0, win_written}, 32'hF);
        check("d_sc", {16'd0, store_count}, 32'd4);

        // Timeout at exactly 500 cycles
        do_reset();
        repeat (499) step();
        check("e_cyc499", {16'd0, cycles}, 32'd499);
        check("e_nodone", {31'd0, done}, 32'd0);
        store(32'h40, 32'h1);
        check("e_done", {31'd0, done}, 32'd1);
        check("e_timeout", {31'd0, timeout}, 32'd1);
        check("e_pass", {31'd0, pass}, 32'd0);
        check("e_cyc500", {16'd0, cycles}, 32'd500);
        check("e_sc1", {16'd0, store_count}, 32'd1);
        store(32'h40, 32'h2);
        check("e_sc_hold", {16'd0, store_count}, 32'd1);
        check("e_cyc_hold", {16'd0, cycles}, 32'd500);

        // Misaligned store into the window
        do_reset();
        store(32'h22, 32'h4080_0000);
        check("f_misalign", {31'd0, misalign}, 32'd1);
        check("f_ww", {28'd0, win_written}, 32'h0);
        check("f_sc", {16'd0, store_count}, 32'd1);
        store(32'h20, 32'h4080_0000);
        store(32'h24, 32'h40A0_0000);
        store(32'h28, 32'h40E0_0000);
        store(32'h2C, 32'h4110_0000);
        PC = 32'h74;
        wait_done(100);
        check("f_pass", {31'd0, pass}, 32'd0);

        // Asynchronous reset mid-run with a store pending
        do_reset();
        store(32'h20, 32'h4080_0000);
        repeat (28) step();
        check("g_cyc29", {16'd0, cycles}, 32'd29);
        MemWrite  = 1'b1;
        DataAdr   = 32'h24;
        WriteData = 32'h40A0_0000;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("g_async");
        @(posedge clk);
        #1;
        check_all_zero("g_held");
        @(negedge clk);
        MemWrite = 1'b0;
        reset    = 1'b1;
        step();
        check("g_restart_cyc", {16'd0, cycles}, 32'd1);
        check("g_restart_sc", {16'd0, store_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
